booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_seq.sv | 124 ++++++++++++
 tb/tb_booth_mul_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Purpose : signed 32x32 -> 64 multiplier, radix-4 Booth, 2 multiplier bits per clock.
// Latency : start accepted at E0, 16 CALC steps E1..E16, result + done at E16, idle at E17.
// Backpres: none; start is only honoured in IDLE or the DONE cycle, the caller stalls on busy.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   multiply request (sampled only when not computing)
//   a, b    two's complement multiplicand / multiplier, latched at the accepting edge
//   busy    registered, high whenever the FSM is not IDLE
//   done    registered one-cycle pulse, result valid in that cycle
//   result  signed product {HI, LO}, held until the next completion
module booth_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        load;

    // m : sign-extended multiplicand, 34 bits so that +-2M never overflows.
    // p : {accumulator[33:0], multiplier[31:0], booth guard bit}.
    logic [33:0] m;
    logic [66:0] p;
    logic [3:0]  cnt;

    logic [33:0] m2;
    logic [33:0] addend;
    logic [33:0] sum;
    logic [66:0] p_step;

    // Radix-4 Booth recode of the low triplet; the guard bit p[0] carries the
    // top bit of the previous pair.
    always_comb begin
        m2     = {m[32:0], 1'b0};
        addend = '0;
        case (p[2:0])
            3'b001, 3'b010: addend = m;
            3'b011:         addend = m2;
            3'b100:         addend = ~m2 + 34'd1;
            3'b101, 3'b110: addend = ~m + 34'd1;
            default:        addend = '0;
        endcase
        // Accumulator add wraps in 34 bits; the arithmetic shift keeps the sign.
        sum    = p[66:33] + addend;
        p_step = {{2{sum[33]}}, sum, p[32:2]};
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The edge leaving DONE is the first edge at which IDLE would
                // sample start, so a request present there is accepted directly;
                // this keeps back-to-back issue at one multiply per 17 cycles.
                // Requests seen earlier (during CALC) are never remembered.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            m      <= '0;
            p      <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            // busy/done are flops tracking the next state, so they carry no
            // combinational path from start.
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            if (load) begin
                m   <= {{2{a[31]}}, a};
                p   <= {34'b0, b, 1'b0};
                cnt <= '0;
            end else if (state == CALC) begin
                p   <= p_step;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    // After 16 double-shifts the product sits above the guard bit.
                    result <= p_step[64:1];
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    booth_mul_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed 64-bit multiplication.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated multiply starting from IDLE, checking latency, busy,
    // result stability before completion, the product and the return to IDLE.
    task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input string name);
        logic [63:0] expv;
        logic [63:0] prev;
        int          bad_k;
        expv  = model(x, y);
        prev  = result;
        bad_k = -1;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();                                  // E0
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (busy !== 1'b1 || done !== 1'b0) bad_k = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (bad_k < 0 && (done !== 1'b0 || busy !== 1'b1 || result !== prev)) bad_k = k;
        end
        tick();                                  // E16
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("FAIL %s timing: edge E%0d busy=%b done=%b result=%h, required busy=1 done=0 result=%h",
                     name, bad_k, busy, done, result, prev);
        end
        checks++;
        if (done !== 1'b1 || result !== expv) begin
            errors++;
            $display("FAIL %s product at E16: done=%b result=%h, required done=1 result=%h",
                     name, done, result, expv);
        end
        tick();                                  // E17
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== expv) begin
            errors++;
            $display("FAIL %s idle at E17: busy=%b done=%b result=%h, required busy=0 done=0 result=%h",
                     name, busy, done, result, expv);
        end
    endtask

    task automatic test_reset();
        logic seen_done;
        // Held in reset with start high: nothing may happen.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        #23;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        // Release between edges with start high: accepted at the next edge.
        rst_n = 1'b1;
        tick();                                  // E0
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_accept: busy=%b, required 1", busy);
        end
        start = 1'b0;
        for (int k = 1; k <= 8; k++) tick();     // up to E8
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        #3;
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || result !== 64'h0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL reset_discard: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd9, "basic_7x9");
    endtask

    task automatic test_signs();
        run_mul(32'hFFFF_FFFD, 32'd5, "neg3_x_5");
        run_mul(32'hFFFF_FFFD, 32'hFFFF_FFFB, "neg3_x_neg5");
    endtask

    task automatic test_extremes();
        run_mul(32'h8000_0000, 32'h8000_0000, "min_x_min");
        run_mul(32'h7FFF_FFFF, 32'h8000_0000, "max_x_min");
        run_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, "max_x_max");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "neg1_x_neg1");
        run_mul(32'h0, $urandom, "zero_x_any");
    endtask

    // start held high while operands change every cycle: acceptances at
    // relative edges 0, 17, 34, results at 16, 33, 50.
    task automatic test_back_to_back();
        logic [31:0] oa [0:50];
        logic [31:0] ob [0:50];
        int          bad_n;
        bad_n = -1;
        for (int n = 0; n <= 50; n++) begin
            oa[n] = $urandom;
            ob[n] = $urandom;
            a     = oa[n];
            b     = ob[n];
            start = 1'b1;
            tick();
            if (n % 17 == 16) begin
                checks++;
                if (done !== 1'b1 || result !== model(oa[n-16], ob[n-16])) begin
                    errors++;
                    $display("FAIL b2b_result edge %0d: done=%b result=%h, required done=1 result=%h",
                             n, done, result, model(oa[n-16], ob[n-16]));
                end
            end else if (bad_n < 0 && (done !== 1'b0 || busy !== 1'b1)) begin
                bad_n = n;
            end
        end
        start = 1'b0;
        checks++;
        if (bad_n >= 0) begin
            errors++;
            $display("FAIL b2b_timing: first bad edge %0d, required busy=1 done=0 off completion edges", bad_n);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run_mul($urandom, $urandom, "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
